// File: rtl/apb_i2c_bridge_slave.sv
// ---------------------------------------------------------------------------
// apb_i2c_bridge_slave
//
// APB responder that turns one APB transfer into one command on an I2C
// master's command port, waits for that command to complete (or time out),
// and then completes the APB transfer with read data and a one-cycle ready.
// The APB address carries the I2C target: addr[7:6] is the device address,
// addr[5:0] is the memory address inside that device.
//
// Parameters
//   SLAVE_ID        sel value that selects this responder
//   TIMEOUT_CYCLES  cycles to wait for i2c_done before giving up (1..65535)
//
// Ports
//   clk, reset            clock (posedge) / asynchronous active-low reset
//   sel, enable, write    APB select, access phase, direction (1 = write)
//   addr, wdata           APB address {dev, mem_addr} and write data
//   rdata, ready, err     APB read data, completion pulse, sticky error
//   i2c_req               command request, held until done or timeout
//   i2c_rw                1 = I2C write, 0 = I2C read
//   i2c_dev, i2c_mem_addr I2C device / in-device memory address
//   i2c_wdata             byte to write
//   i2c_done, i2c_nack    completion pulse and NACK flag from the I2C master
//   i2c_rdata             byte read, valid with i2c_done
// ---------------------------------------------------------------------------
module apb_i2c_bridge_slave #(
    parameter logic [1:0] SLAVE_ID       = 2'd2,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       enable,
    input  logic       write,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ready,
    output logic       err,
    output logic       i2c_req,
    output logic       i2c_rw,
    output logic [1:0] i2c_dev,
    output logic [5:0] i2c_mem_addr,
    output logic [7:0] i2c_wdata,
    input  logic       i2c_done,
    input  logic       i2c_nack,
    input  logic [7:0] i2c_rdata
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             rw_q, rw_d;
    logic [1:0]       dev_q, dev_d;
    logic [5:0]       mem_q, mem_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             sel_hit;
    logic             timeout;
    logic [CNT_W-1:0] cnt_inc;

    assign sel_hit = (sel == SLAVE_ID);
    assign timeout = (cnt_q == CNT_LAST);
    // Saturating increment: the counter must never wrap back into range.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
            rw_q    <= 1'b0;
            dev_q   <= 2'd0;
            mem_q   <= 6'd0;
            wdata_q <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            mem_q   <= mem_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        mem_d   = mem_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // Only a setup phase starts a command; an access phase with
                // no preceding setup is not a valid transfer start.
                if (sel_hit && !enable) begin
                    rw_d    = write;
                    dev_d   = addr[7:6];
                    mem_d   = addr[5:0];
                    wdata_d = wdata;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                // Completion takes priority over timeout and over abort.
                if (i2c_done) begin
                    if (i2c_nack) begin
                        err_d = 1'b1;
                        if (!rw_q) rdata_d = 8'hFF;
                    end else if (!rw_q) begin
                        rdata_d = i2c_rdata;
                    end
                    state_d = S_DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    rdata_d = 8'hFF;
                    state_d = S_DONE;
                end else if (!sel_hit) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The APB side is gone, but the I2C command is in flight and
                // must be allowed to finish; its data is discarded.
                cnt_d = cnt_inc;
                if (i2c_done) begin
                    if (i2c_nack) err_d = 1'b1;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (!sel_hit || enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign i2c_req      = (state_q == S_REQ) || (state_q == S_DRAIN);
    // Combinational so the pulse lands in the first DONE cycle the master
    // is in its access phase, one cycle after i2c_done.
    assign ready        = (state_q == S_DONE) && sel_hit && enable;
    assign rdata        = rdata_q;
    assign err          = err_q;
    assign i2c_rw       = rw_q;
    assign i2c_dev      = dev_q;
    assign i2c_mem_addr = mem_q;
    assign i2c_wdata    = wdata_q;

endmodule

// File: tb/tb_apb_i2c_bridge_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_i2c_bridge_slave
//
// Directed bench for apb_i2c_bridge_slave. The stimulus tasks keep a
// transaction-level picture of what every output should be in each cycle
// (exp_*), and a negedge process compares the DUT against it every cycle.
// Literal expectations after each scenario pin the picture itself.
// ---------------------------------------------------------------------------
module tb_apb_i2c_bridge_slave;

    localparam int         TO = 8;
    localparam logic [1:0] ID = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic       enable, write;
    logic [7:0] addr, wdata;
    logic [7:0] rdata;
    logic       ready, err;
    logic       i2c_req, i2c_rw;
    logic [1:0] i2c_dev;
    logic [5:0] i2c_mem_addr;
    logic [7:0] i2c_wdata;
    logic       i2c_done, i2c_nack;
    logic [7:0] i2c_rdata;

    apb_i2c_bridge_slave #(.SLAVE_ID(ID), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .sel(sel), .enable(enable), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .i2c_req(i2c_req), .i2c_rw(i2c_rw), .i2c_dev(i2c_dev),
        .i2c_mem_addr(i2c_mem_addr), .i2c_wdata(i2c_wdata),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int req_hi = 0;
    int rdy_cnt = 0;

    logic       exp_ready, exp_req, exp_err, exp_rw;
    logic [7:0] exp_rdata, exp_wdata;
    logic [1:0] exp_dev;
    logic [5:0] exp_mem;

    logic [7:0] cap_rdata, cap_wdata;
    logic [1:0] cap_dev;
    logic [5:0] cap_mem;
    logic       cap_rw, cap_err, cap_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        check("ready",    32'(ready),        32'(exp_ready));
        check("i2c_req",  32'(i2c_req),      32'(exp_req));
        check("err",      32'(err),          32'(exp_err));
        check("rdata",    32'(rdata),        32'(exp_rdata));
        check("i2c_rw",   32'(i2c_rw),       32'(exp_rw));
        check("i2c_dev",  32'(i2c_dev),      32'(exp_dev));
        check("i2c_mem",  32'(i2c_mem_addr), 32'(exp_mem));
        check("i2c_wdat", 32'(i2c_wdata),    32'(exp_wdata));
        if (i2c_req) req_hi++;
        if (ready)   rdy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sel = 2'd0; enable = 1'b0; exp_ready = 1'b0;
        repeat (n) tick();
    endtask

    task automatic expect_setup(input logic w, input logic [7:0] a, input logic [7:0] wd);
        exp_req = 1'b1; exp_rw = w; exp_dev = a[7:6]; exp_mem = a[5:0];
        exp_wdata = wd; exp_err = 1'b0;
    endtask

    // One APB transfer. d = cycle of the command (1 = first request cycle)
    // in which i2c_done is returned; d = 0 means never, i.e. timeout.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] wd,
                        input int d, input logic nk, input logic [7:0] rd);
        int  n;
        bit  got;
        got = (d > 0) && (d <= TO);
        n   = got ? d : TO;
        sel = ID; enable = 1'b0; write = w; addr = a; wdata = wd;
        exp_ready = 1'b0;
        tick();
        expect_setup(w, a, wd);
        enable = 1'b1;
        for (int c = 1; c <= n; c++) begin
            if (got && c == n) begin
                i2c_done = 1'b1; i2c_nack = nk; i2c_rdata = rd;
            end
            tick();
            i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
        end
        exp_req = 1'b0; exp_ready = 1'b1;
        if (got) begin
            if (nk) begin
                exp_err = 1'b1;
                if (!w) exp_rdata = 8'hFF;
            end else if (!w) begin
                exp_rdata = rd;
            end
        end else begin
            exp_err = 1'b1; exp_rdata = 8'hFF;
        end
        #2;
        cap_rdata = rdata; cap_err = err; cap_ready = ready; cap_rw = i2c_rw;
        cap_dev = i2c_dev; cap_mem = i2c_mem_addr; cap_wdata = i2c_wdata;
        tick();
        exp_ready = 1'b0;
    endtask

    // Read transfer abandoned by the master in request cycle 2; the command
    // completes in cycle d (d >= 3) without ever producing ready.
    task automatic abort_xfer(input logic [7:0] a, input int d, input logic nk);
        sel = ID; enable = 1'b0; write = 1'b0; addr = a; wdata = 8'h00;
        exp_ready = 1'b0;
        tick();
        expect_setup(1'b0, a, 8'h00);
        enable = 1'b1;
        tick();
        for (int c = 2; c <= d; c++) begin
            if (c == 2) begin sel = 2'd0; enable = 1'b0; end
            if (c == d) begin i2c_done = 1'b1; i2c_nack = nk; i2c_rdata = 8'hEE; end
            tick();
            i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
        end
        exp_req = 1'b0;
        if (nk) exp_err = 1'b1;
    endtask

    int r0;

    initial begin
        reset = 1'b0; sel = 2'd0; enable = 1'b0; write = 1'b0;
        addr = 8'h00; wdata = 8'h00;
        i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
        exp_ready = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_rw = 1'b0;
        exp_rdata = 8'h00; exp_wdata = 8'h00; exp_dev = 2'd0; exp_mem = 6'd0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Write then back-to-back read
        r0 = rdy_cnt;
        xfer(1'b1, 8'h41, 8'h05, 3, 1'b0, 8'h00);
        check("t1_dev",   32'(cap_dev),   32'd1);
        check("t1_mem",   32'(cap_mem),   32'd1);
        check("t1_wdata", 32'(cap_wdata), 32'h05);
        check("t1_rw",    32'(cap_rw),    32'd1);
        check("t1_ready", 32'(cap_ready), 32'd1);
        check("t1_err",   32'(cap_err),   32'd0);
        check("t1_rdata", 32'(cap_rdata), 32'h00);
        xfer(1'b0, 8'h41, 8'h00, 2, 1'b0, 8'hA5);
        check("t2_rdata", 32'(cap_rdata), 32'hA5);
        check("t2_rw",    32'(cap_rw),    32'd0);
        check("t12_pulses", 32'(rdy_cnt - r0), 32'd2);
        idle(2);

        // NACK read with minimum latency, then a clean write clears err
        xfer(1'b0, 8'h82, 8'h00, 1, 1'b1, 8'h33);
        check("t3_rdata", 32'(cap_rdata), 32'hFF);
        check("t3_err",   32'(cap_err),   32'd1);
        check("t3_dev",   32'(cap_dev),   32'd2);
        check("t3_mem",   32'(cap_mem),   32'd2);
        xfer(1'b1, 8'hC5, 8'h7E, 4, 1'b0, 8'h00);
        check("t3b_err",   32'(cap_err),   32'd0);
        check("t3b_rdata", 32'(cap_rdata), 32'hFF);
        idle(1);
        xfer(1'b0, 8'h3C, 8'h00, 2, 1'b0, 8'h5A);
        check("t3c_rdata", 32'(cap_rdata), 32'h5A);

        // Timeout
        idle(1);
        req_hi = 0;
        xfer(1'b0, 8'h10, 8'h00, 0, 1'b0, 8'h00);
        check("t4_req_cycles", 32'(req_hi), 32'd8);
        check("t4_rdata", 32'(cap_rdata), 32'hFF);
        check("t4_err",   32'(cap_err),   32'd1);
        check("t4_ready", 32'(cap_ready), 32'd1);
        idle(1);

        // Master abort, then a normal transfer
        r0 = rdy_cnt;
        req_hi = 0;
        abort_xfer(8'h41, 5, 1'b0);
        idle(2);
        check("t5_no_ready", 32'(rdy_cnt - r0), 32'd0);
        check("t5_req_cycles", 32'(req_hi), 32'd5);
        xfer(1'b0, 8'h41, 8'h00, 2, 1'b0, 8'h12);
        check("t5_rdata", 32'(cap_rdata), 32'h12);
        check("t5_err",   32'(cap_err),   32'd0);
        idle(1);

        // Access phase with no setup is ignored
        sel = ID; enable = 1'b1;
        repeat (3) tick();
        idle(1);

        // Reset in the middle of a request
        sel = ID; enable = 1'b0; write = 1'b0; addr = 8'h41;
        tick();
        expect_setup(1'b0, 8'h41, 8'h00);
        enable = 1'b1;
        tick();
        reset = 1'b0;
        exp_req = 1'b0; exp_ready = 1'b0; exp_err = 1'b0; exp_rw = 1'b0;
        exp_rdata = 8'h00; exp_wdata = 8'h00; exp_dev = 2'd0; exp_mem = 6'd0;
        #1;
        check("t6_req_async", 32'(i2c_req), 32'd0);
        check("t6_rdata_rst", 32'(rdata),   32'h00);
        tick();
        sel = 2'd0; enable = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Wrong slave select never starts a command
        req_hi = 0;
        sel = 2'd1; enable = 1'b0; write = 1'b1; addr = 8'hFF; wdata = 8'hAA;
        tick();
        enable = 1'b1;
        repeat (3) tick();
        idle(1);
        check("t6_wrong_sel", 32'(req_hi), 32'd0);

        xfer(1'b0, 8'hFE, 8'h00, 3, 1'b0, 8'h69);
        check("t6_recover", 32'(cap_rdata), 32'h69);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
